// File: rtl/adder_nibble_sequencer.sv
// rtl/adder_nibble_sequencer.sv - W-bit add/subtract through one shared 4-bit ripple slice, LSB nibble first; optional ADD_SEQ_SUB_EN adds the sub port

// 4-bit ripple-carry adder slice
module adder_nibble_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c0,
  output logic [3:0] s,
  output logic       c4
);

  logic [4:0] c;

  // ripple the carry through four full adders
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = c0;
    for (int i = 0; i < 4; i++) begin
      s[i]     = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    c4 = c[4];
  end

endmodule

// sequencer: IDLE -> RUN (NIBBLES cycles) -> DONE (one cycle) -> IDLE
module adder_nibble_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] A,
  input  logic [4*NIBBLES-1:0] B,
  input  logic                 cin,
`ifdef ADD_SEQ_SUB_EN
  input  logic                 sub,
`endif
  output logic                 ready,
  output logic                 done,
  output logic [4*NIBBLES-1:0] Sum,
  output logic                 cout,
  output logic                 ovf
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [W-1:0]    opa;
  logic [W-1:0]    opb;
  logic            carry;
  logic [IW-1:0]   idx;

  logic [W-1:0]    b_eff;
  logic            c_eff;
  logic [3:0]      a_nib;
  logic [3:0]      b_nib;
  logic [3:0]      s;
  logic            c4;

  // operand conditioning at the accepting edge: subtract is A + ~B + 1
  always_comb begin
    b_eff = B;
    c_eff = cin;
`ifdef ADD_SEQ_SUB_EN
    if (sub) begin
      b_eff = ~B;
      c_eff = 1'b1;
    end
`endif
  end

  // select the nibble the shared slice works on this cycle
  always_comb begin
    a_nib = opa[4*idx +: 4];
    b_nib = opb[4*idx +: 4];
  end

  adder_nibble_slice u_slice (
    .a  (a_nib),
    .b  (b_nib),
    .c0 (carry),
    .s  (s),
    .c4 (c4)
  );

  // controller, operand/carry registers and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ready <= 1'b1;
      done  <= 1'b0;
      Sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      carry <= 1'b0;
      idx   <= '0;
      opa   <= '0;
      opb   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            opa   <= A;
            opb   <= b_eff;
            carry <= c_eff;
            idx   <= '0;
            ready <= 1'b0;
            state <= RUN;
          end
        end
        RUN: begin
          Sum[4*idx +: 4] <= s;
          carry           <= c4;
          if (idx == LAST) begin
            idx   <= '0;
            cout  <= c4;
            ovf   <= (opa[W-1] == opb[W-1]) && (s[3] != opa[W-1]);
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
